movement_control: RTL and testbench

- Sequencing FSM directly upstream of the sprite movement datapath.
- Samples the four direction keys once per frame tick and owns the authoritative sprite position (x_pos/y_pos), which drives the datapath Xin/Yin.
- Issues the 4-bit control code sequence CLEAR -> MOVE -> DRAW, handshaking on the datapath's done (enable) pulse, with a watchdog timeout.

---
 rtl/movement_control.sv | 173 +++++++++++++++++
 tb/tb_movement_control.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/movement_control.sv
// Frame-tick driven CLEAR -> MOVE -> DRAW sequencer for the sprite datapath.
// Owns the authoritative sprite position and watches the datapath done handshake.
module movement_control #(
    parameter int TICK_CYCLES  = 833333,
    parameter int X_MAX        = 159,
    parameter int Y_MAX        = 119,
    parameter int X_INIT       = 50,
    parameter int Y_INIT       = 50,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       draw_done,
    output logic [3:0] control,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic       busy,
    output logic       timeout_err
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int WW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    localparam logic [3:0] CODE_IDLE  = 4'b0000;
    localparam logic [3:0] CODE_CLEAR = 4'b0101;
    localparam logic [3:0] CODE_DRAW  = 4'b0110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MOVE  = 3'd2,
        ST_DRAW  = 3'd3
    } state_t;

    state_t          state_r, state_s;
    logic [1:0]      dir_r, dir_s;
    logic [WW-1:0]   wd_r, wd_s;
    logic [TW-1:0]   tick_cnt_r;
    logic            tick_s;
    logic            pending_r;
    logic            init_draw_r;
    logic            consume_s;
    logic            init_done_s;
    logic            abort_s;
    logic            move_s;
    logic [7:0]      x_pos_r, x_next_s;
    logic [6:0]      y_pos_r, y_next_s;
    logic [3:0]      control_r;
    logic            busy_r;
    logic            timeout_err_r;

    // Direction codes sit right after IDLE: left=1, right=2, up=3, down=4.
    function automatic logic [3:0] ctrl_code(input state_t st, input logic [1:0] d);
        case (st)
            ST_IDLE:  ctrl_code = CODE_IDLE;
            ST_CLEAR: ctrl_code = CODE_CLEAR;
            ST_MOVE:  ctrl_code = {2'b00, d} + 4'd1;
            ST_DRAW:  ctrl_code = CODE_DRAW;
            default:  ctrl_code = CODE_IDLE;
        endcase
    endfunction

    assign tick_s = (tick_cnt_r == TW'(TICK_CYCLES - 1));

    // Next-state, key sampling and watchdog logic.
    always_comb begin
        state_s     = state_r;
        dir_s       = dir_r;
        wd_s        = wd_r;
        consume_s   = 1'b0;
        init_done_s = 1'b0;
        abort_s     = 1'b0;
        move_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (init_draw_r) begin
                    state_s     = ST_DRAW;
                    init_done_s = 1'b1;
                    wd_s        = {WW{1'b0}};
                end else if (pending_r) begin
                    consume_s = 1'b1;
                    if (key_left | key_right | key_up | key_down) begin
                        state_s = ST_CLEAR;
                        wd_s    = {WW{1'b0}};
                        if (key_left)       dir_s = 2'd0;
                        else if (key_right) dir_s = 2'd1;
                        else if (key_up)    dir_s = 2'd2;
                        else                dir_s = 2'd3;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR, ST_DRAW: begin
                if (draw_done) begin
                    state_s = (state_r == ST_CLEAR) ? ST_MOVE : ST_IDLE;
                end else if (wd_r == WW'(DONE_TIMEOUT - 1)) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    wd_s = wd_r + WW'(1);
                end
            end
            ST_MOVE: begin
                move_s  = 1'b1;
                state_s = ST_DRAW;
                wd_s    = {WW{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Clamped position update, applied only at the end of the MOVE cycle.
    always_comb begin
        x_next_s = x_pos_r;
        y_next_s = y_pos_r;
        if (move_s) begin
            case (dir_r)
                2'd0:    x_next_s = (x_pos_r != 8'd0)         ? x_pos_r - 8'd1 : x_pos_r;
                2'd1:    x_next_s = (x_pos_r < 8'(X_MAX))     ? x_pos_r + 8'd1 : x_pos_r;
                2'd2:    y_next_s = (y_pos_r != 7'd0)         ? y_pos_r - 7'd1 : y_pos_r;
                2'd3:    y_next_s = (y_pos_r < 7'(Y_MAX))     ? y_pos_r + 7'd1 : y_pos_r;
                default: x_next_s = x_pos_r;
            endcase
        end else begin
            x_next_s = x_pos_r;
        end
    end

    // State, counters and registered outputs (control/busy track the next state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            dir_r         <= 2'd0;
            wd_r          <= {WW{1'b0}};
            tick_cnt_r    <= {TW{1'b0}};
            pending_r     <= 1'b0;
            init_draw_r   <= 1'b1;
            x_pos_r       <= 8'(X_INIT);
            y_pos_r       <= 7'(Y_INIT);
            control_r     <= CODE_IDLE;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            dir_r         <= dir_s;
            wd_r          <= wd_s;
            tick_cnt_r    <= tick_s ? {TW{1'b0}} : tick_cnt_r + TW'(1);
            pending_r     <= tick_s | (pending_r & ~consume_s);
            init_draw_r   <= init_draw_r & ~init_done_s;
            x_pos_r       <= x_next_s;
            y_pos_r       <= y_next_s;
            control_r     <= ctrl_code(state_s, dir_s);
            busy_r        <= (state_s != ST_IDLE);
            timeout_err_r <= timeout_err_r | abort_s;
        end
    end

    assign control     = control_r;
    assign busy        = busy_r;
    assign x_pos       = x_pos_r;
    assign y_pos       = y_pos_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_movement_control.sv
// Bench for movement_control: directed scenarios plus randomized keys/latencies,
// checked every cycle against a sequence-level model of the sprite controller.
module tb_movement_control;

    localparam int TICK = 8;
    localparam int XMAX = 159;
    localparam int YMAX = 119;
    localparam int XI   = 50;
    localparam int YI   = 50;
    localparam int TO   = 64;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_MOVE  = 2;
    localparam int M_DRAW  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
    logic       draw_done = 1'b0;
    logic [3:0] control;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic       busy;
    logic       timeout_err;

    movement_control #(
        .TICK_CYCLES(TICK), .X_MAX(XMAX), .Y_MAX(YMAX),
        .X_INIT(XI), .Y_INIT(YI), .DONE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
        .draw_done(draw_done), .control(control), .x_pos(x_pos), .y_pos(y_pos),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model: what the sprite controller is doing this cycle
    int m_mode, m_x, m_y, m_err, m_tcnt, m_pend, m_init, m_dir, m_wait;

    // Datapath emulation: done rises 'lat' cycles into a CLEAR/DRAW code
    int         lat = 16;
    bit         hold_low = 1'b0;
    int         run = 0;
    logic [3:0] prev_ctrl = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    endtask

    function automatic int exp_ctrl();
        case (m_mode)
            M_CLEAR: return 5;
            M_MOVE:  return m_dir + 1;
            M_DRAW:  return 6;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit tick, took;
        if (reset) begin
            m_mode = M_IDLE; m_x = XI; m_y = YI; m_err = 0;
            m_tcnt = 0; m_pend = 0; m_init = 1; m_dir = 0; m_wait = 0;
        end else begin
            tick   = (m_tcnt == TICK - 1);
            m_tcnt = (m_tcnt + 1) % TICK;
            took   = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (m_init != 0) begin
                        m_init = 0; m_mode = M_DRAW; m_wait = 0;
                    end else if (m_pend != 0) begin
                        took = 1'b1;
                        if (key_left | key_right | key_up | key_down) begin
                            m_dir  = key_left ? 0 : key_right ? 1 : key_up ? 2 : 3;
                            m_mode = M_CLEAR; m_wait = 0;
                        end
                    end
                end
                M_CLEAR, M_DRAW: begin
                    if (draw_done) m_mode = (m_mode == M_CLEAR) ? M_MOVE : M_IDLE;
                    else if (m_wait + 1 >= TO) begin m_err = 1; m_mode = M_IDLE; end
                    else m_wait++;
                end
                default: begin
                    if (m_dir == 0) m_x = (m_x > 0) ? m_x - 1 : 0;
                    if (m_dir == 1) m_x = (m_x + 1 > XMAX) ? XMAX : m_x + 1;
                    if (m_dir == 2) m_y = (m_y > 0) ? m_y - 1 : 0;
                    if (m_dir == 3) m_y = (m_y + 1 > YMAX) ? YMAX : m_y + 1;
                    m_mode = M_DRAW; m_wait = 0;
                end
            endcase
            if (tick) m_pend = 1;
            else if (took) m_pend = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (control == 4'd5 || control == 4'd6) begin
            if (control == prev_ctrl) run++;
            else run = 0;
            draw_done = !hold_low && (run >= lat);
        end else begin
            run = 0;
            draw_done = 1'b0;
        end
        prev_ctrl = control;
    endtask

    task automatic wait_code(input logic [3:0] code, input int budget, input string name);
        int k = 0;
        while (control != code && k < budget) begin
            cycle();
            k++;
        end
        if (control != code) check(name, control, code);
    endtask

    task automatic run_len(input logic [3:0] code, output int n);
        n = 0;
        while (control == code && n < 300) begin
            cycle();
            n++;
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("control", control, exp_ctrl());
            check("busy", busy, (m_mode != M_IDLE) ? 1 : 0);
            check("x_pos", x_pos, m_x);
            check("y_pos", y_pos, m_y);
            check("timeout_err", timeout_err, m_err);
        end
    end

    initial begin
        int n, n2;
        // Reset and power-up draw
        reset = 1'b1;
        repeat (3) cycle();
        chk_en = 1'b1;
        check("rst_control", control, 0);
        check("rst_busy", busy, 0);
        check("rst_x", x_pos, 50);
        check("rst_y", y_pos, 50);
        check("rst_err", timeout_err, 0);
        reset = 1'b0;
        cycle();
        check("init_draw", control, 6);
        wait_code(4'd0, 100, "init_draw_end");
        check("init_x", x_pos, 50);

        // Single right move with a 16-cycle datapath
        key_right = 1'b1;
        wait_code(4'd5, 50, "right_start");
        key_right = 1'b0;
        run_len(4'd5, n);
        check("right_clear_len", n, 17);
        check("x_during_move", x_pos, 50);
        run_len(4'd2, n);
        check("right_move_len", n, 1);
        check("right_x", x_pos, 51);
        check("right_y", y_pos, 50);
        run_len(4'd6, n);
        check("right_draw_len", n, 17);
        check("right_end", control, 0);

        // Priority: left beats right and up
        key_left = 1'b1; key_right = 1'b1; key_up = 1'b1;
        wait_code(4'd5, 50, "prio_start");
        key_left = 1'b0; key_right = 1'b0; key_up = 1'b0;
        run_len(4'd5, n);
        check("prio_code", control, 1);
        cycle();
        check("prio_x", x_pos, 50);
        check("prio_y", y_pos, 50);
        wait_code(4'd0, 100, "prio_end");

        // Boundaries with an instant datapath
        lat = 0;
        key_right = 1'b1;
        repeat (1300) cycle();
        check("bound_xmax", x_pos, 159);
        n2 = 0;
        repeat (100) begin cycle(); if (control == 4'd2) n2++; end
        check("bound_right_runs", (n2 > 0) ? 1 : 0, 1);
        check("bound_xmax_hold", x_pos, 159);
        key_right = 1'b0;
        key_up = 1'b1;
        repeat (600) cycle();
        check("bound_y0", y_pos, 0);
        n2 = 0;
        repeat (100) begin cycle(); if (control == 4'd3) n2++; end
        check("bound_up_runs", (n2 > 0) ? 1 : 0, 1);
        check("bound_y0_hold", y_pos, 0);
        key_up = 1'b0;
        wait_code(4'd0, 20, "bound_end");

        // Watchdog abort in CLEAR
        hold_low = 1'b1; lat = 16;
        key_right = 1'b1;
        wait_code(4'd5, 50, "to_start");
        key_right = 1'b0;
        run_len(4'd5, n);
        check("to_clear_len", n, 64);
        check("to_control", control, 0);
        check("to_busy", busy, 0);
        check("to_err", timeout_err, 1);
        check("to_x", x_pos, 159);
        hold_low = 1'b0; lat = 3;
        key_left = 1'b1;
        wait_code(4'd5, 50, "to_after_start");
        key_left = 1'b0;
        wait_code(4'd0, 100, "to_after_end");
        check("to_err_sticky", timeout_err, 1);
        check("to_after_x", x_pos, 158);

        // Reset mid-DRAW, then dropped ticks give one more sequence
        lat = 30;
        key_right = 1'b1;
        wait_code(4'd6, 200, "mid_draw");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_control", control, 0);
        check("mid_rst_x", x_pos, 50);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", timeout_err, 0);
        cycle();
        check("mid_rst_redraw", control, 6);
        wait_code(4'd0, 100, "redraw_end");
        wait_code(4'd5, 3, "pending_seq");
        key_right = 1'b0;
        wait_code(4'd0, 200, "pending_seq_end");
        n = 0;
        repeat (40) begin cycle(); if (control == 4'd5) n++; end
        check("no_extra_seq", n, 0);

        // Randomized traffic
        lat = 5;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0)
                {key_left, key_right, key_up, key_down} = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) lat = $urandom_range(0, 24);
            if ($urandom_range(0, 63) == 0) hold_low = ~hold_low;
            reset = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0;
        cycle();
        chk_en = 1'b0;
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
